snake_dir_ctrl: RTL and testbench

- Merges the four debounced push-button strobes and the IR remote decoder output into one queued snake-direction command stream.
- Sits between the key_debounce/remote_rcv stages and vga_display, and replaces vga_display's ad-hoc key and con_flag handling.
- Applies the no-reverse rule, buffers up to CMD_DEPTH turns, and releases one turn per game move tick. A fast double-tap (e.g. up then left) is therefore not lost within one move period.

---
 rtl/snake_dir_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: merges push-button and IR direction commands into a
// queued turn stream released one per move tick. Option: SNAKE_PAUSE_EN.
module snake_dir_ctrl #(
  parameter int         CMD_DEPTH = 2,
  parameter logic [1:0] INIT_DIR  = 2'd3,
  parameter logic [7:0] IR_UP     = 8'h18,
  parameter logic [7:0] IR_DOWN   = 8'h52,
  parameter logic [7:0] IR_LEFT   = 8'h08,
  parameter logic [7:0] IR_RIGHT  = 8'h5A,
  parameter logic [7:0] IR_OK     = 8'h1C
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       kf_up,
  input  logic       kf_down,
  input  logic       kf_left,
  input  logic       kf_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       ir_data_en,
  input  logic       ir_repeat_en,
  input  logic [7:0] ir_data,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic       pause,
  output logic       q_full,
  output logic [7:0] drop_cnt
);

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam logic [PW-1:0] PTR_MAX  = PW'(CMD_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CMD_DEPTH);

  logic [1:0]    fifo_q [CMD_DEPTH];
  logic [1:0]    fifo_d [CMD_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic          dir_chg_q, dir_chg_d;
  logic          q_full_q, q_full_d;
  logic [7:0]    drop_q, drop_d;

  logic [3:0]    press;
  logic          cand_v;
  logic [1:0]    cand_dir;
  logic          ir_ok;
  logic          hold;
  logic          flush;

  logic [PW-1:0] tail_idx;
  logic [1:0]    last_dir;
  logic          pop;
  logic          accept;
  logic          push;
  logic          drop;

  // Pick at most one command: keys (up>down>left>right) beat IR.
  always_comb begin
    press    = {kf_up & ~key_up, kf_down & ~key_down,
                kf_left & ~key_left, kf_right & ~key_right};
    cand_v   = 1'b0;
    cand_dir = 2'd0;
    ir_ok    = 1'b0;
    case (1'b1)
      press[3]: begin cand_v = 1'b1; cand_dir = 2'd0; end
      press[2]: begin cand_v = 1'b1; cand_dir = 2'd1; end
      press[1]: begin cand_v = 1'b1; cand_dir = 2'd2; end
      press[0]: begin cand_v = 1'b1; cand_dir = 2'd3; end
      ir_data_en: begin
        case (ir_data)
          IR_UP:    begin cand_v = 1'b1; cand_dir = 2'd0; end
          IR_DOWN:  begin cand_v = 1'b1; cand_dir = 2'd1; end
          IR_LEFT:  begin cand_v = 1'b1; cand_dir = 2'd2; end
          IR_RIGHT: begin cand_v = 1'b1; cand_dir = 2'd3; end
          IR_OK:    ir_ok = 1'b1;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef SNAKE_PAUSE_EN
  logic pause_q, pause_d;
  logic unused_ok;

  // IR_OK toggles pause; entering pause flushes the turn queue.
  always_comb begin
    pause_d = pause_q ^ ir_ok;
    flush   = ir_ok & ~pause_q;
    hold    = pause_q | flush;
  end

  // Pause level register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) pause_q <= 1'b0;
    else         pause_q <= pause_d;
  end

  assign pause     = pause_q;
  assign unused_ok = ir_repeat_en;
`else
  logic unused_ok;
  assign hold      = 1'b0;
  assign flush     = 1'b0;
  assign pause     = 1'b0;
  assign unused_ok = ir_repeat_en ^ ir_ok;
`endif

  // Filter the candidate against the queue tail, then push/pop the FIFO.
  always_comb begin
    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    drop_d    = drop_q;
    tail_idx  = (wr_ptr_q == '0) ? PTR_MAX : wr_ptr_q - PW'(1);
    last_dir  = (cnt_q != '0) ? fifo_q[tail_idx] : dir_q;
    pop       = move_tick & (cnt_q != '0) & ~hold;
    // same direction and reverse both share the vertical/horizontal bit
    accept    = cand_v & ~hold & (cand_dir[1] != last_dir[1]);
    push      = accept & (~q_full_q | pop);
    drop      = accept & q_full_q & ~pop;
    dir_chg_d = pop;
    if (pop) begin
      dir_d    = fifo_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = cand_dir;
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    q_full_d = (cnt_d == CNT_FULL);
  end

  // Control and status registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      dir_q     <= INIT_DIR;
      dir_chg_q <= 1'b0;
      q_full_q  <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      dir_chg_q <= dir_chg_d;
      q_full_q  <= q_full_d;
      drop_q    <= drop_d;
    end
  end

  // Turn storage; contents only matter behind the valid count.
  always_ff @(posedge sys_clk) begin
    fifo_q <= fifo_d;
  end

  assign dir      = dir_q;
  assign dir_chg  = dir_chg_q;
  assign q_full   = q_full_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the turn controller.
module tb_snake_dir_ctrl;

  localparam int DEPTH = 2;
`ifdef SNAKE_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       kf_up = 0, kf_down = 0, kf_left = 0, kf_right = 0;
  logic       key_up = 1, key_down = 1, key_left = 1, key_right = 1;
  logic       ir_data_en = 0, ir_repeat_en = 0;
  logic [7:0] ir_data = 8'h00;
  logic       move_tick = 0;
  logic [1:0] dir;
  logic       dir_chg, pause, q_full;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int m_q[$];
  int m_dir = 3;
  bit m_chg = 0;
  int m_drop = 0;
  bit m_pause = 0;

  snake_dir_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .kf_up(kf_up), .kf_down(kf_down),
    .kf_left(kf_left), .kf_right(kf_right),
    .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right),
    .ir_data_en(ir_data_en), .ir_repeat_en(ir_repeat_en),
    .ir_data(ir_data), .move_tick(move_tick),
    .dir(dir), .dir_chg(dir_chg), .pause(pause),
    .q_full(q_full), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void model_step(input logic [3:0] pr,
                                     input logic ire,
                                     input logic [7:0] ird,
                                     input logic tk,
                                     input logic rs);
    int cmd;
    int last;
    bit ok;
    bit pop;
    bit push;
    if (rs) begin
      m_q.delete();
      m_dir = 3; m_chg = 0; m_drop = 0; m_pause = 0;
      return;
    end
    cmd = -1; ok = 0; push = 0;
    if (pr[3]) cmd = 0;
    else if (pr[2]) cmd = 1;
    else if (pr[1]) cmd = 2;
    else if (pr[0]) cmd = 3;
    else if (ire) begin
      if (ird == 8'h18) cmd = 0;
      else if (ird == 8'h52) cmd = 1;
      else if (ird == 8'h08) cmd = 2;
      else if (ird == 8'h5A) cmd = 3;
      else if (ird == 8'h1C) ok = PAUSE_EN;
    end
    if (ok) begin
      if (!m_pause) m_q.delete();
      m_pause = !m_pause;
      m_chg = 0;
      return;
    end
    pop = tk && m_q.size() > 0 && !m_pause;
    last = (m_q.size() > 0) ? m_q[$] : m_dir;
    m_chg = pop;
    if (cmd >= 0 && !m_pause && cmd != last && cmd != (last ^ 1)) begin
      if (m_q.size() == DEPTH && !pop) begin
        if (m_drop < 255) m_drop++;
      end else push = 1;
    end
    if (pop) m_dir = m_q.pop_front();
    if (push) m_q.push_back(cmd);
  endfunction

  task automatic step(input logic [3:0] kf, input logic [3:0] kl,
                      input logic ire, input logic [7:0] ird,
                      input logic tk, input logic rs);
    {kf_up, kf_down, kf_left, kf_right} = kf;
    {key_up, key_down, key_left, key_right} = kl;
    ir_data_en = ire;
    ir_data = ird;
    move_tick = tk;
    sys_rst = rs;
    ir_repeat_en = 1'($urandom_range(0, 1));
    @(posedge sys_clk);
    model_step(kf & ~kl, ire, ird, tk, rs);
    #1;
  endtask

  task automatic idle();  step(4'h0, 4'hF, 0, 8'h00, 0, 0); endtask
  task automatic tick();  step(4'h0, 4'hF, 0, 8'h00, 1, 0); endtask
  task automatic reset(); step(4'h0, 4'hF, 0, 8'h00, 0, 1); endtask
  task automatic press(input int d);
    logic [3:0] m;
    m = 4'b1000 >> d;
    step(m, ~m, 0, 8'h00, 0, 0);
  endtask

  task automatic test_reset();
    reset(); reset();
    n_checks++; if (dir !== 2'd3) begin n_errors++;
      $display("FAIL reset_dir: got %0d want 3", dir); end
    n_checks++; if (dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL reset_chg: got %b want 0", dir_chg); end
    n_checks++; if (pause !== 1'b0) begin n_errors++;
      $display("FAIL reset_pause: got %b want 0", pause); end
    n_checks++; if (q_full !== 1'b0) begin n_errors++;
      $display("FAIL reset_full: got %b want 0", q_full); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_errors++;
      $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    tick();
    n_checks++; if (dir !== 2'd3 || dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL empty_tick: got dir=%0d chg=%b want 3/0",
               dir, dir_chg); end
    idle();
    n_checks++; if (dir_chg !== 1'b0 || drop_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL empty_tick_after: got chg=%b drop=%0d want 0/0",
               dir_chg, drop_cnt); end
  endtask

  task automatic test_basic_turn();
    reset();
    press(0);
    n_checks++; if (q_full !== 1'b0) begin n_errors++;
      $display("FAIL one_entry_full: got %b want 0", q_full); end
    tick();
    n_checks++; if (dir !== 2'd0 || dir_chg !== 1'b1) begin n_errors++;
      $display("FAIL turn_up: got dir=%0d chg=%b want 0/1", dir, dir_chg); end
    idle();
    n_checks++; if (dir !== 2'd0 || dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL turn_up_pulse: got dir=%0d chg=%b want 0/0",
               dir, dir_chg); end
    step(4'b0010, 4'b1101, 0, 8'h00, 1, 0);
    n_checks++; if (dir !== 2'd0 || dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL same_cycle_entry: got dir=%0d chg=%b want 0/0",
               dir, dir_chg); end
    tick();
    n_checks++; if (dir !== 2'd2 || dir_chg !== 1'b1) begin n_errors++;
      $display("FAIL turn_left: got dir=%0d chg=%b want 2/1",
               dir, dir_chg); end
  endtask

  task automatic test_reverse();
    reset();
    press(2);
    tick();
    n_checks++; if (dir !== 2'd3 || dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL reverse: got dir=%0d chg=%b want 3/0", dir, dir_chg); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_errors++;
      $display("FAIL reverse_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    reset();
    press(0); press(2); press(1);
    n_checks++; if (q_full !== 1'b1 || drop_cnt !== 8'd1) begin n_errors++;
      $display("FAIL overflow: got full=%b drop=%0d want 1/1",
               q_full, drop_cnt); end
    tick();
    n_checks++; if (dir !== 2'd0) begin n_errors++;
      $display("FAIL ovf_tick1: got %0d want 0", dir); end
    tick();
    n_checks++; if (dir !== 2'd2) begin n_errors++;
      $display("FAIL ovf_tick2: got %0d want 2", dir); end
    tick();
    n_checks++; if (dir !== 2'd2 || dir_chg !== 1'b0 || q_full !== 1'b0)
    begin n_errors++;
      $display("FAIL ovf_tick3: got dir=%0d chg=%b full=%b want 2/0/0",
               dir, dir_chg, q_full); end
  endtask

  task automatic test_priority();
    reset();
    step(4'b0100, 4'b1011, 1, 8'h18, 0, 0);
    tick();
    n_checks++; if (dir !== 2'd1) begin n_errors++;
      $display("FAIL key_beats_ir: got %0d want 1", dir); end
    step(4'h0, 4'hF, 1, 8'h08, 0, 0);
    tick();
    n_checks++; if (dir !== 2'd2) begin n_errors++;
      $display("FAIL ir_left: got %0d want 2", dir); end
  endtask

  task automatic test_back_to_back();
    reset();
    press(0); press(2);
    step(4'b0100, 4'b1011, 0, 8'h00, 1, 0);
    n_checks++; if (dir !== 2'd0 || q_full !== 1'b1 || drop_cnt !== 8'd0)
    begin n_errors++;
      $display("FAIL full_pop_push: got dir=%0d full=%b drop=%0d want 0/1/0",
               dir, q_full, drop_cnt); end
    tick();
    n_checks++; if (dir !== 2'd2) begin n_errors++;
      $display("FAIL b2b_tick1: got %0d want 2", dir); end
    tick();
    n_checks++; if (dir !== 2'd1 || q_full !== 1'b0) begin n_errors++;
      $display("FAIL b2b_tick2: got dir=%0d full=%b want 1/0",
               dir, q_full); end
  endtask

  task automatic test_mid_reset();
    reset();
    press(0);
    reset();
    tick();
    n_checks++; if (dir !== 2'd3 || dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL mid_reset: got dir=%0d chg=%b want 3/0", dir, dir_chg); end
  endtask

  task automatic test_saturation();
    reset();
    press(0); press(2);
    for (int i = 0; i < 260; i++) press(1);
    n_checks++; if (drop_cnt !== 8'd255 || q_full !== 1'b1) begin n_errors++;
      $display("FAIL drop_sat: got drop=%0d full=%b want 255/1",
               drop_cnt, q_full); end
  endtask

`ifdef SNAKE_PAUSE_EN
  task automatic test_pause();
    reset();
    press(0);
    step(4'h0, 4'hF, 1, 8'h1C, 0, 0);
    tick();
    n_checks++; if (pause !== 1'b1 || dir !== 2'd3 || q_full !== 1'b0 ||
                    dir_chg !== 1'b0) begin n_errors++;
      $display("FAIL pause_on: got p=%b dir=%0d full=%b chg=%b want 1/3/0/0",
               pause, dir, q_full, dir_chg); end
    step(4'h0, 4'hF, 1, 8'h1C, 0, 0);
    press(0);
    tick();
    n_checks++; if (pause !== 1'b0 || dir !== 2'd0) begin n_errors++;
      $display("FAIL pause_off: got p=%b dir=%0d want 0/0", pause, dir); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] codes [6];
    logic [3:0] kf;
    logic [7:0] ird;
    codes[0] = 8'h18; codes[1] = 8'h52; codes[2] = 8'h08;
    codes[3] = 8'h5A; codes[4] = 8'h1C; codes[5] = 8'h33;
    reset();
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) kf[b] = ($urandom_range(0, 4) == 0);
      ird = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                        : codes[$urandom_range(0, 5)];
      step(kf, 4'($urandom), ($urandom_range(0, 3) == 0), ird,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0));
      n_checks++;
      if (dir !== 2'(m_dir) || dir_chg !== m_chg || pause !== m_pause ||
          q_full !== (m_q.size() == DEPTH) || drop_cnt !== 8'(m_drop))
      begin
        n_errors++;
        $display("FAIL random[%0d]: got dir=%0d chg=%b p=%b full=%b drop=%0d want %0d/%b/%b/%b/%0d",
                 i, dir, dir_chg, pause, q_full, drop_cnt, m_dir, m_chg,
                 m_pause, (m_q.size() == DEPTH), m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_turn();
    test_reverse();
    test_overflow();
    test_priority();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
`ifdef SNAKE_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
